// File: rtl/id_stage.sv
// id_stage -- instruction decode and issue stage of the scalar pipeline.
//
// Splits a 12-bit instruction word {opcode, rd, rs1, rs2} into regfile and
// ALU control fields and registers them as the ID/EX pipeline register.
// A small writeback scoreboard remembers the destination of each
// instruction still in flight and holds off any ALU instruction that would
// read one of those registers before its result reaches the regfile.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   fetch presents a valid instruction
//   instr      instruction word {opcode[11:9], rd[8:6], rs1[5:3], rs2[2:0]}
//   in_ready   stage accepts instr this cycle (combinational)
//   out_valid  registered outputs carry an issued instruction
//   opcode     ALU opcode
//   adr1       destination register
//   adr2       source 1 register
//   adr3       source 2 register
//   write      regfile write enable
//   read2      regfile port-2 read enable
//   read3      regfile port-3 read enable
//   select     1 = immediate to regfile, 0 = ALU result
//   dat        zero-extended immediate data
//   stall_cnt  saturating count of hazard-stall cycles
module id_stage #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3,
  parameter int WB_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [11:0]       instr,
  output logic              in_ready,
  output logic              out_valid,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] adr1,
  output logic [ADDR_W-1:0] adr2,
  output logic [ADDR_W-1:0] adr3,
  output logic              write,
  output logic              read2,
  output logic              read3,
  output logic              select,
  output logic [DATA_W-1:0] dat,
  output logic [7:0]        stall_cnt
);

  localparam logic [2:0] OP_LDI = 3'b000;

  // Raw instruction fields
  logic [2:0]        op_s;
  logic [ADDR_W-1:0] rd_s;
  logic [ADDR_W-1:0] rs1_s;
  logic [ADDR_W-1:0] rs2_s;

  // Decoded control fields for the instruction currently presented
  logic [ADDR_W-1:0] dec_adr1_s;
  logic [ADDR_W-1:0] dec_adr2_s;
  logic [ADDR_W-1:0] dec_adr3_s;
  logic              dec_write_s;
  logic              dec_read2_s;
  logic              dec_read3_s;
  logic              dec_select_s;
  logic [DATA_W-1:0] dec_dat_s;

  // Scoreboard of in-flight destinations; entry 0 is the youngest
  logic              sb_valid_r [WB_LAT];
  logic [ADDR_W-1:0] sb_addr_r  [WB_LAT];

  logic match_s;
  logic hazard_s;
  logic accept_s;

  assign op_s  = instr[11:9];
  assign rd_s  = ADDR_W'(instr[8:6]);
  assign rs1_s = ADDR_W'(instr[5:3]);
  assign rs2_s = ADDR_W'(instr[2:0]);

  // Decode the presented instruction into regfile/ALU control fields
  always_comb begin
    dec_adr1_s   = {ADDR_W{1'b0}};
    dec_adr2_s   = {ADDR_W{1'b0}};
    dec_adr3_s   = {ADDR_W{1'b0}};
    dec_write_s  = 1'b0;
    dec_read2_s  = 1'b0;
    dec_read3_s  = 1'b0;
    dec_select_s = 1'b0;
    dec_dat_s    = {DATA_W{1'b0}};
    case (op_s)
      OP_LDI: begin
        // LDI reuses the rs1/rs2 bit positions as a 6-bit immediate
        dec_adr1_s   = rd_s;
        dec_write_s  = 1'b1;
        dec_select_s = 1'b1;
        dec_dat_s    = DATA_W'(instr[5:0]);
      end
      3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111: begin
        dec_adr1_s  = rd_s;
        dec_adr2_s  = rs1_s;
        dec_adr3_s  = rs2_s;
        dec_write_s = 1'b1;
        dec_read2_s = 1'b1;
        dec_read3_s = 1'b1;
      end
      default: begin
        dec_write_s = 1'b0;
      end
    endcase
  end

  // RAW hazard: any source matches a valid in-flight destination.
  // An entry dropping off at this edge is still compared, which is what
  // makes a dependent stall exactly WB_LAT cycles behind its producer.
  always_comb begin
    match_s = 1'b0;
    for (int i = 0; i < WB_LAT; i++) begin
      match_s = match_s |
                (sb_valid_r[i] & ((sb_addr_r[i] == rs1_s) | (sb_addr_r[i] == rs2_s)));
    end
    hazard_s = match_s & (op_s != OP_LDI);
  end

  assign in_ready = rst_n & ~hazard_s;
  assign accept_s = in_valid & in_ready;

  // Scoreboard shift register; one slot per edge until writeback
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WB_LAT; i++) begin
        sb_valid_r[i] <= 1'b0;
        sb_addr_r[i]  <= {ADDR_W{1'b0}};
      end
    end else begin
      sb_valid_r[0] <= accept_s;
      sb_addr_r[0]  <= accept_s ? rd_s : {ADDR_W{1'b0}};
      for (int i = 1; i < WB_LAT; i++) begin
        sb_valid_r[i] <= sb_valid_r[i-1];
        sb_addr_r[i]  <= sb_addr_r[i-1];
      end
    end
  end

  // ID/EX pipeline register; a bubble kills only the enables and keeps
  // the data fields stable to avoid needless toggling downstream
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      opcode    <= 3'b000;
      adr1      <= {ADDR_W{1'b0}};
      adr2      <= {ADDR_W{1'b0}};
      adr3      <= {ADDR_W{1'b0}};
      write     <= 1'b0;
      read2     <= 1'b0;
      read3     <= 1'b0;
      select    <= 1'b0;
      dat       <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      out_valid <= 1'b1;
      opcode    <= op_s;
      adr1      <= dec_adr1_s;
      adr2      <= dec_adr2_s;
      adr3      <= dec_adr3_s;
      write     <= dec_write_s;
      read2     <= dec_read2_s;
      read3     <= dec_read3_s;
      select    <= dec_select_s;
      dat       <= dec_dat_s;
    end else begin
      out_valid <= 1'b0;
      write     <= 1'b0;
      read2     <= 1'b0;
      read3     <= 1'b0;
    end
  end

  // Saturating hazard-stall counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= 8'd0;
    end else if (in_valid && hazard_s && (stall_cnt != 8'hFF)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode and issue stage of the scalar pipeline. It accepts 12-bit instruction words from fetch and splits them into the register-file and ALU control fields (opcode, addresses, read/write enables, immediate-select, immediate data). It registers them as the ID/EX pipeline register and interlocks read-after-write hazards with a writeback scoreboard. Sits directly upstream of regfile, the immediate/ALU-result 2:1 mux and the ALU.

## Interface
- DATA_W, 12, datapath width; immediate is zero-extended to this width
- ADDR_W, 3, register address width (8 registers)
- WB_LAT, 2, edges from issue until the issued instruction's result is written into regfile (1..4)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, reset is synchronous and active-low
- in_valid  input  1  fetch presents a valid instruction
- instr  input  12  instruction word {opcode[11:9], rd[8:6], rs1[5:3], rs2[2:0]}
- in_ready  output  1  stage accepts instr this cycle (combinational)
- out_valid  output  1  registered outputs carry an issued instruction
- opcode  output  3  ALU opcode
- adr1  output  ADDR_W  destination register
- adr2  output  ADDR_W  source 1
- adr3  output  ADDR_W  source 2
- write  output  1  regfile write enable
- read2  output  1  regfile port-2 read enable
- read3  output  1  regfile port-3 read enable
- select  output  1  1 = immediate to regfile, 0 = ALU result
- dat  output  DATA_W  immediate data
- stall_cnt  output  8  saturating count of hazard-stall cycles

## Operation
- Decode by opcode:
  - 000 LDI: write=1, select=1, read2=read3=0, adr1=rd, adr2=adr3=0, dat={0, instr[5:0]}.
  - 001 ADD, 010 SUB, 011 MUL, 100 IMUL, 101 FADD, 110 FMUL, 111 CMP: write=1, select=0, read2=read3=1, adr1=rd, adr2=rs1, adr3=rs2, dat=0.
- Scoreboard: WB_LAT entries of {valid, addr}, shifted every clock. The entry-0 input is {1, rd} on accept and {0, 0} otherwise. The last entry drops off.
- Hazard: a non-LDI instruction has rs1 or rs2 equal to the addr of any valid scoreboard entry. LDI never hazards.
- Write-after-write needs no check, because issue is in order.
- in_ready = rst_n & ~hazard. Accept = in_valid & in_ready.
- On accept: all output fields load the decoded values and out_valid=1.
- On no accept (bubble): out_valid, write, read2 and read3 clear to 0. opcode, adr1–3, select and dat hold their previous values.
- stall_cnt increments on every cycle with in_valid=1 and hazard=1. It saturates at 255 and never wraps.
- Downstream has no backpressure; issued outputs are consumed in the cycle they are valid.

## Timing
- Reset (rst_n low at an edge):
  - All outputs become 0 and stall_cnt becomes 0.
  - Scoreboard entries are invalidated.
  - in_ready=0 while rst_n is low.
- Reset mid-stall: the pending instruction is dropped and the scoreboard is cleared. After release, in_ready=1.
- Latency is 1 cycle from the accept edge to valid outputs. Throughput is 1 instruction per cycle with no hazards.
- A dependent instruction presented in the cycle right after its producer's accept stalls exactly WB_LAT cycles. Each independent instruction between the two reduces the stall by 1, with a minimum of 0.
- instr and in_valid must stay stable while in_valid=1 and in_ready=0. Changing them under stall is a protocol error and its behaviour is unspecified.
- A source equal to a scoreboard entry that is dropping off at this edge still stalls this cycle. It is compared against current contents only.

## Test plan
- Reset: rst_n=0 for 2 cycles with in_valid=1, instr=0x281 -> out_valid=0, write=0, in_ready=0, stall_cnt=0; first cycle after release in_ready=1.
- LDI: 0x005 accepted -> next cycle out_valid=1, write=1, select=1, adr1=0, read2=read3=0, dat=0x005.
- Back-to-back independent stream: 0x005, 0x043, each held 1 cycle -> accepted on consecutive edges, 0 stall cycles, stall_cnt=0.
- RAW stall: 0x005, 0x043, then 0x281 (ADD R2,R0,R1) -> in_ready=0 for 2 cycles, then 0x281 issues with opcode=001, adr1=2, adr2=0, adr3=1, read2=read3=1, select=0. Bubble cycles show write=0. stall_cnt=2.
- Partial distance: 0x281, 0x4C1 (SUB R3,R0,R1), 0x313 (ADD R4,R2,R3) after the registers are settled -> 0x313 stalls 2 cycles on R3 (R2 clears earlier). stall_cnt advances by 2.
- Saturation: hold a hazard for 300 cycles using a producer recirculated by force, or a WB_LAT=4 back-to-back dependent chain -> stall_cnt stops at 255 and never wraps.
